// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-organised data memory with registered read.
// Optional misaligned word-access fault: define LSU_ALIGN_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isLoad,
  input  logic        byteAccess,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        fault,
  output logic [31:0] memAddr,
  output logic [31:0] memDataIn,
  output logic        memEnable,
  output logic        memReadNotWrite,
  input  logic [31:0] memDataOut
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state, stateNext;
  logic        reqLoad, reqByte;
  logic [1:0]  reqLane;
  logic [7:0]  reqByteData;
  logic        misaligned_c;
  logic        faultNext;
  logic [31:0] memDataInNext;
  logic [31:0] mergedWord_c;
  logic [31:0] laneByte_c;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned_c = !byteAccess && (address[1:0] != 2'b00);
`else
  assign misaligned_c = 1'b0;
`endif

  // Read word with the addressed lane replaced by the store byte
  always_comb begin
    mergedWord_c = memDataOut;
    case (reqLane)
      2'd0:    mergedWord_c[7:0]   = reqByteData;
      2'd1:    mergedWord_c[15:8]  = reqByteData;
      2'd2:    mergedWord_c[23:16] = reqByteData;
      default: mergedWord_c[31:24] = reqByteData;
    endcase
  end

  assign laneByte_c = {24'h0, memDataOut[{reqLane, 3'b000} +: 8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    faultNext     = 1'b0;
    memDataInNext = 32'h0;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned_c) begin
            stateNext = DONE;
            faultNext = 1'b1;
          end else if (isLoad || byteAccess) begin
            stateNext = RD;
          end else begin
            stateNext     = WR;
            memDataInNext = storeData;
          end
        end
      end
      RD:  stateNext = CAP;
      CAP: begin
        // Only loads and byte stores pass through CAP
        if (reqLoad) begin
          stateNext = DONE;
        end else begin
          stateNext     = WR;
          memDataInNext = mergedWord_c;
        end
      end
      WR:      stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      fault           <= 1'b0;
      memEnable       <= 1'b0;
      memReadNotWrite <= 1'b1;
      memAddr         <= 32'h0;
      memDataIn       <= 32'h0;
      loadData        <= 32'h0;
      reqLoad         <= 1'b0;
      reqByte         <= 1'b0;
      reqLane         <= 2'b00;
      reqByteData     <= 8'h0;
    end else begin
      busy            <= (stateNext != IDLE);
      done            <= (stateNext == DONE);
      fault           <= faultNext;
      memEnable       <= (stateNext == RD) || (stateNext == WR);
      memReadNotWrite <= (stateNext != WR);
      memDataIn       <= memDataInNext;
      if (state == IDLE && start) begin
        reqLoad     <= isLoad;
        reqByte     <= byteAccess;
        reqLane     <= address[1:0];
        reqByteData <= storeData[7:0];
        memAddr     <= {2'b00, address[31:2]};
      end
      if (state == CAP && reqLoad) begin
        loadData <= reqByte ? laneByte_c : memDataOut;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, isLoad, byteAccess;
  logic [31:0] address, storeData;
  logic        busy, done, fault;
  logic [31:0] loadData, memAddr, memDataIn, memDataOut;
  logic        memEnable, memReadNotWrite;

  int nCmp = 0;
  int nBad = 0;

  logic [31:0] mem [0:31];

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .isLoad(isLoad),
    .byteAccess(byteAccess), .address(address), .storeData(storeData),
    .busy(busy), .done(done), .loadData(loadData), .fault(fault),
    .memAddr(memAddr), .memDataIn(memDataIn), .memEnable(memEnable),
    .memReadNotWrite(memReadNotWrite), .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // One-cycle registered-read word memory
  always @(posedge clk) begin
    if (memEnable) begin
      if (memReadNotWrite) memDataOut <= mem[memAddr[4:0]];
      else                 mem[memAddr[4:0]] <= memDataIn;
    end
  end

  // Issue one request and observe it until done (bounded)
  task automatic doReq(input logic ld, input logic bt, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] data,
                       output logic flt, output int enCnt, output logic [31:0] addrSeen);
    lat = 0; enCnt = 0; data = 32'h0; flt = 1'b0; addrSeen = 32'h0;
    @(negedge clk);
    start = 1'b1; isLoad = ld; byteAccess = bt; address = a; storeData = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (memEnable) begin
        enCnt++;
        addrSeen = memAddr;
      end
      if (done) begin
        lat = c; data = loadData; flt = fault;
        break;
      end
    end
    if (lat == 0) begin
      nCmp++; nBad++;
      $display("FAIL req_timeout: addr=%h got no done within 20 cycles, required done", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; isLoad = 1'b0; byteAccess = 1'b0;
    address = 32'h0; storeData = 32'h0;
    repeat (2) @(negedge clk);
    nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL reset_busy: got %b want 0", busy); end
    nCmp++; if (done !== 1'b0) begin nBad++; $display("FAIL reset_done: got %b want 0", done); end
    nCmp++; if (fault !== 1'b0) begin nBad++; $display("FAIL reset_fault: got %b want 0", fault); end
    nCmp++; if (memEnable !== 1'b0) begin nBad++; $display("FAIL reset_memEnable: got %b want 0", memEnable); end
    nCmp++; if (memReadNotWrite !== 1'b1) begin nBad++; $display("FAIL reset_rnw: got %b want 1", memReadNotWrite); end
    nCmp++; if (memAddr !== 32'h0) begin nBad++; $display("FAIL reset_memAddr: got %h want 0", memAddr); end
    nCmp++; if (memDataIn !== 32'h0) begin nBad++; $display("FAIL reset_memDataIn: got %h want 0", memDataIn); end
    nCmp++; if (loadData !== 32'h0) begin nBad++; $display("FAIL reset_loadData: got %h want 0", loadData); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    int lat, en; logic [31:0] d, as; logic f;
    doReq(1'b0, 1'b0, 32'h0C, 32'h12345678, lat, d, f, en, as);
    nCmp++; if (lat !== 2) begin nBad++; $display("FAIL word_store_latency: got %0d want 2", lat); end
    nCmp++; if (as !== 32'd3) begin nBad++; $display("FAIL word_store_memAddr: got %h want 3", as); end
    nCmp++; if (mem[3] !== 32'h12345678) begin nBad++; $display("FAIL word_store_mem: got %h want 12345678", mem[3]); end
    doReq(1'b1, 1'b0, 32'h0C, 32'h0, lat, d, f, en, as);
    nCmp++; if (lat !== 3) begin nBad++; $display("FAIL word_load_latency: got %0d want 3", lat); end
    nCmp++; if (d !== 32'h12345678) begin nBad++; $display("FAIL word_load_data: got %h want 12345678", d); end
  endtask

  task automatic test_byte_store();
    int lat, en; logic [31:0] d, as; logic f;
    doReq(1'b0, 1'b0, 32'h08, 32'hAABBCCDD, lat, d, f, en, as);
    doReq(1'b0, 1'b1, 32'h09, 32'h000000EE, lat, d, f, en, as);
    nCmp++; if (lat !== 4) begin nBad++; $display("FAIL byte_store_latency: got %0d want 4", lat); end
    nCmp++; if (en !== 2) begin nBad++; $display("FAIL byte_store_mem_cycles: got %0d want 2", en); end
    doReq(1'b1, 1'b0, 32'h08, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'hAABBEEDD) begin nBad++; $display("FAIL byte_store_merge: got %h want aabbeedd", d); end
    doReq(1'b0, 1'b1, 32'h0B, 32'hFFFFFF55, lat, d, f, en, as);
    doReq(1'b1, 1'b0, 32'h08, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'h55BBEEDD) begin nBad++; $display("FAIL byte_store_lane3: got %h want 55bbeedd", d); end
  endtask

  task automatic test_byte_load();
    int lat, en; logic [31:0] d, as; logic f;
    doReq(1'b0, 1'b0, 32'h08, 32'hAABBCCDD, lat, d, f, en, as);
    doReq(1'b1, 1'b1, 32'h0B, 32'h0, lat, d, f, en, as);
    nCmp++; if (lat !== 3) begin nBad++; $display("FAIL byte_load_latency: got %0d want 3", lat); end
    nCmp++; if (d !== 32'h000000AA) begin nBad++; $display("FAIL byte_load_lane3: got %h want 000000aa", d); end
    doReq(1'b1, 1'b1, 32'h08, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'h000000DD) begin nBad++; $display("FAIL byte_load_lane0: got %h want 000000dd", d); end
    doReq(1'b1, 1'b1, 32'h0A, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'h000000BB) begin nBad++; $display("FAIL byte_load_lane2: got %h want 000000bb", d); end
  endtask

  task automatic test_reset_mid();
    int lat, en; logic [31:0] d, as; logic f;
    doReq(1'b0, 1'b0, 32'h10, 32'h11111111, lat, d, f, en, as);
    @(negedge clk);
    start = 1'b1; isLoad = 1'b0; byteAccess = 1'b0; address = 32'h10; storeData = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    nCmp++; if (memEnable !== 1'b1) begin nBad++; $display("FAIL mid_reset_pre_en: got %b want 1", memEnable); end
    reset = 1'b1;
    #1;
    nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    nCmp++; if (memEnable !== 1'b0) begin nBad++; $display("FAIL mid_reset_memEnable: got %b want 0", memEnable); end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doReq(1'b1, 1'b0, 32'h10, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'h11111111) begin nBad++; $display("FAIL mid_reset_mem_kept: got %h want 11111111", d); end
  endtask

  task automatic test_start_while_busy();
    int doneCnt, en; logic [31:0] d;
    doneCnt = 0; en = 0; d = 32'h0;
    @(negedge clk);
    start = 1'b1; isLoad = 1'b1; byteAccess = 1'b0; address = 32'h0C; storeData = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin
        isLoad = 1'b0; address = 32'h10; storeData = 32'hBAD0BAD0;
      end
      if (memEnable) en++;
      if (done) begin doneCnt++; d = loadData; end
    end
    start = 1'b0;
    nCmp++; if (doneCnt !== 1) begin nBad++; $display("FAIL busy_done_count: got %0d want 1", doneCnt); end
    nCmp++; if (en !== 1) begin nBad++; $display("FAIL busy_mem_cycles: got %0d want 1", en); end
    nCmp++; if (d !== 32'h12345678) begin nBad++; $display("FAIL busy_load_data: got %h want 12345678", d); end
    nCmp++; if (mem[4] !== 32'h11111111) begin nBad++; $display("FAIL busy_mem4: got %h want 11111111", mem[4]); end
  endtask

  task automatic test_align();
    int lat, en; logic [31:0] d, as; logic f;
    doReq(1'b1, 1'b0, 32'h08, 32'h0, lat, d, f, en, as);
    nCmp++; if (d !== 32'hAABBCCDD) begin nBad++; $display("FAIL align_preload: got %h want aabbccdd", d); end
    doReq(1'b1, 1'b0, 32'h0E, 32'h0, lat, d, f, en, as);
`ifdef LSU_ALIGN_CHECK_EN
    nCmp++; if (lat !== 1) begin nBad++; $display("FAIL align_latency: got %0d want 1", lat); end
    nCmp++; if (f !== 1'b1) begin nBad++; $display("FAIL align_fault: got %b want 1", f); end
    nCmp++; if (en !== 0) begin nBad++; $display("FAIL align_mem_cycles: got %0d want 0", en); end
    nCmp++; if (d !== 32'hAABBCCDD) begin nBad++; $display("FAIL align_data_kept: got %h want aabbccdd", d); end
`else
    nCmp++; if (lat !== 3) begin nBad++; $display("FAIL align_latency: got %0d want 3", lat); end
    nCmp++; if (f !== 1'b0) begin nBad++; $display("FAIL align_fault: got %b want 0", f); end
    nCmp++; if (as !== 32'd3) begin nBad++; $display("FAIL align_memAddr: got %h want 3", as); end
    nCmp++; if (d !== 32'h12345678) begin nBad++; $display("FAIL align_data: got %h want 12345678", d); end
`endif
    doReq(1'b1, 1'b1, 32'h0E, 32'h0, lat, d, f, en, as);
    nCmp++; if (f !== 1'b0) begin nBad++; $display("FAIL align_byte_fault: got %b want 0", f); end
    nCmp++; if (d !== 32'h00000034) begin nBad++; $display("FAIL align_byte_data: got %h want 00000034", d); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_byte_load();
    test_reset_mid();
    test_start_while_busy();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
